// File: rtl/eeprom_pkg.sv
// Shared definitions for the SPI EEPROM logging path: FSM state encodings,
// EEPROM opcodes and the status-register WIP bit position.
package eeprom_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_WR,
    S_GAP,
    S_POLL,
    S_NEXT,
    S_FULL,
    S_ERR
  } sched_state_t;

  typedef enum logic [2:0] {
    P_IDLE,
    P_CMD,
    P_CMD_W,
    P_RD,
    P_RD_W,
    P_CHK
  } poll_state_t;

  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_DUMMY = 8'h00;

  localparam int unsigned WIP_BIT = 0;

endpackage

// File: rtl/eeprom_status_poller.sv
// Status poller: issues one RDSR opcode, then keeps clocking dummy bytes
// (continuous RDSR) until WIP clears. Optional poll limit under the
// POLL_TIMEOUT_EN macro; without it the poller never gives up.
module eeprom_status_poller
  import eeprom_pkg::*;
#(
  parameter int unsigned MAX_POLLS = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       spi_done,
  input  logic [7:0] spi_rx,
  output logic       spi_load,
  output logic [7:0] spi_tx,
  output logic       ncs,
  output logic       ready,
  output logic       timeout
);

  poll_state_t state;
  logic        wip;

  // Only the WIP bit of the status byte matters here.
  logic unused_rx;
  assign unused_rx = ^spi_rx;

`ifdef POLL_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_POLLS + 1);
  logic [CW-1:0] poll_cnt;

  assign timeout = (state == P_CHK) && wip && (poll_cnt == CW'(MAX_POLLS));
`else
  localparam int unsigned unused_max_polls = MAX_POLLS;

  assign timeout = 1'b0;
`endif

  // ready is combinational so the scheduler leaves POLL in the CHK cycle.
  assign ready = (state == P_CHK) && !wip;

  // Poll sequencer with registered SPI strobes and chip select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= P_IDLE;
      spi_load <= 1'b0;
      spi_tx   <= OP_DUMMY;
      ncs      <= 1'b1;
      wip      <= 1'b0;
`ifdef POLL_TIMEOUT_EN
      poll_cnt <= '0;
`endif
    end else begin
      spi_load <= 1'b0;
      case (state)
        P_IDLE:  if (start) state <= P_CMD;
        P_CMD: begin
          ncs      <= 1'b0;
          spi_tx   <= OP_RDSR;
          spi_load <= 1'b1;
          state    <= P_CMD_W;
        end
        P_CMD_W: if (spi_done) state <= P_RD;
        P_RD: begin
          spi_tx   <= OP_DUMMY;
          spi_load <= 1'b1;
          state    <= P_RD_W;
        end
        P_RD_W: if (spi_done) begin
          wip   <= spi_rx[WIP_BIT];
`ifdef POLL_TIMEOUT_EN
          poll_cnt <= poll_cnt + 1'b1;
`endif
          state <= P_CHK;
        end
        P_CHK: begin
          if (!wip || timeout) begin
            ncs   <= 1'b1;
`ifdef POLL_TIMEOUT_EN
            poll_cnt <= '0;
`endif
            state <= P_IDLE;
          end else begin
            state <= P_RD;
          end
        end
        default: state <= P_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/eeprom_page_scheduler.sv
// Page scheduler: launches a page write per full buffer, hands the SPI
// engine to the status poller after a chip-select gap, then advances the
// page address until memory is full. Optional macro POLL_TIMEOUT_EN adds
// the stuck-device timeout and the sticky err flag.
module eeprom_page_scheduler
  import eeprom_pkg::*;
#(
  parameter int unsigned PAGE_AW   = 8,
  parameter int unsigned NUM_PAGES = 256,
  parameter int unsigned MAX_POLLS = 1000,
  parameter int unsigned CS_GAP    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               page_ready,
  output logic               wr_start,
  input  logic               wr_page_done,
  output logic               bus_sel,
  output logic               spi_load,
  output logic [7:0]         spi_tx,
  input  logic               spi_done,
  input  logic [7:0]         spi_rx,
  output logic               ncs,
  output logic [PAGE_AW-1:0] page_addr,
  output logic               busy,
  output logic               mem_full,
  output logic               err
);

  localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [PAGE_AW-1:0] LAST_PAGE = PAGE_AW'(NUM_PAGES - 1);

  sched_state_t  state;
  logic [GW-1:0] gap_cnt;
  logic          poll_start;
  logic          poll_ready;
  logic          poll_timeout;

  assign poll_start = (state == S_GAP) && (gap_cnt == '0);

`ifndef POLL_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = poll_timeout;
  assign err = 1'b0;
`endif

  eeprom_status_poller #(
    .MAX_POLLS (MAX_POLLS)
  ) u_poller (
    .clk      (clk),
    .rst      (rst),
    .start    (poll_start),
    .spi_done (spi_done),
    .spi_rx   (spi_rx),
    .spi_load (spi_load),
    .spi_tx   (spi_tx),
    .ncs      (ncs),
    .ready    (poll_ready),
    .timeout  (poll_timeout)
  );

  // Page sequencing FSM with registered outputs; wr_start is raised on entry
  // to START so it is high for exactly the START cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_start  <= 1'b0;
      bus_sel   <= 1'b0;
      page_addr <= '0;
      busy      <= 1'b0;
      mem_full  <= 1'b0;
      gap_cnt   <= '0;
`ifdef POLL_TIMEOUT_EN
      err       <= 1'b0;
`endif
    end else begin
      wr_start <= 1'b0;
      case (state)
        S_IDLE: if (page_ready) begin
          wr_start <= 1'b1;
          busy     <= 1'b1;
          state    <= S_START;
        end
        S_START: state <= S_WAIT_WR;
        S_WAIT_WR: if (wr_page_done) begin
          bus_sel <= 1'b1;
          gap_cnt <= GW'(CS_GAP - 1);
          state   <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == '0) state <= S_POLL;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        S_POLL: begin
          if (poll_ready) begin
            bus_sel <= 1'b0;
            state   <= S_NEXT;
          end
`ifdef POLL_TIMEOUT_EN
          else if (poll_timeout) begin
            bus_sel <= 1'b0;
            err     <= 1'b1;
            busy    <= 1'b0;
            state   <= S_ERR;
          end
`endif
        end
        S_NEXT: begin
          busy <= 1'b0;
          if (page_addr == LAST_PAGE) begin
            mem_full <= 1'b1;
            state    <= S_FULL;
          end else begin
            page_addr <= page_addr + 1'b1;
            state     <= S_IDLE;
          end
        end
        S_FULL, S_ERR: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_page_scheduler.sv
// Scoreboard bench for eeprom_page_scheduler with page-writer and SPI
// engine models; the timeout scenario runs when POLL_TIMEOUT_EN is defined.
module tb_eeprom_page_scheduler;

  localparam int unsigned PAGE_AW   = 3;
  localparam int unsigned NUM_PAGES = 4;
  localparam int unsigned MAX_POLLS = 5;
  localparam int unsigned CS_GAP    = 3;

  typedef enum int {EV_WR, EV_LOAD, EV_END, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int unsigned val;
    bit          full;
  } ev_t;
  typedef logic [7:0] bq_t[$];

  logic               clk;
  logic               rst;
  logic               page_ready;
  logic               wr_start;
  logic               wr_page_done;
  logic               bus_sel;
  logic               spi_load;
  logic [7:0]         spi_tx;
  logic               spi_done;
  logic               spi_done_eng;
  logic               spi_done_noise;
  logic [7:0]         spi_rx;
  logic               ncs;
  logic [PAGE_AW-1:0] page_addr;
  logic               busy;
  logic               mem_full;
  logic               err;

  ev_t         exp_q[$];
  logic [7:0]  status_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned model_page = 0;

  assign spi_done = spi_done_eng | spi_done_noise;

  eeprom_page_scheduler #(
    .PAGE_AW   (PAGE_AW),
    .NUM_PAGES (NUM_PAGES),
    .MAX_POLLS (MAX_POLLS),
    .CS_GAP    (CS_GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .page_ready   (page_ready),
    .wr_start     (wr_start),
    .wr_page_done (wr_page_done),
    .bus_sel      (bus_sel),
    .spi_load     (spi_load),
    .spi_tx       (spi_tx),
    .spi_done     (spi_done),
    .spi_rx       (spi_rx),
    .ncs          (ncs),
    .page_addr    (page_addr),
    .busy         (busy),
    .mem_full     (mem_full),
    .err          (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got wait bound expired expected DUT event", name);
  endtask

  function automatic ev_t mk(input ev_kind_t k, input int unsigned v, input bit f);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.full = f;
    return e;
  endfunction

  task automatic pop_exp(input ev_kind_t k, output ev_t e, output bit ok);
    checks++;
    ok = 1'b0;
    e  = mk(EV_END, 0, 1'b0);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s expected nothing", k.name());
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k) begin
        errors++;
        $display("FAIL event_order: got %s expected %s", k.name(), e.kind.name());
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // Reference model: one page = write start at the current page, one RDSR
  // opcode, one dummy read per status byte up to the first with WIP clear,
  // then the page address advances or memory-full is flagged.
  task automatic issue_page(input bq_t st);
    exp_q.push_back(mk(EV_WR, model_page, 1'b0));
    exp_q.push_back(mk(EV_LOAD, 32'h05, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      status_q.push_back(st[i]);
      exp_q.push_back(mk(EV_LOAD, 32'h00, 1'b0));
      if (st[i][0] == 1'b0) break;
    end
    if (model_page == NUM_PAGES - 1) begin
      exp_q.push_back(mk(EV_END, model_page, 1'b1));
    end else begin
      model_page++;
      exp_q.push_back(mk(EV_END, model_page, 1'b0));
    end
  endtask

  task automatic rand_script(output bq_t st);
    int unsigned n;
    logic [7:0] b;
    st = {};
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255)) | 8'h01;
      st.push_back(b);
    end
    b = 8'($urandom_range(0, 255)) & 8'hFE;
    st.push_back(b);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_wr_start"},  32'(wr_start),  0);
    chk({tag, "_bus_sel"},   32'(bus_sel),   0);
    chk({tag, "_spi_load"},  32'(spi_load),  0);
    chk({tag, "_spi_tx"},    32'(spi_tx),    0);
    chk({tag, "_ncs"},       32'(ncs),       1);
    chk({tag, "_page_addr"}, 32'(page_addr), 0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_mem_full"},  32'(mem_full),  0);
    chk({tag, "_err"},       32'(err),       0);
  endtask

  task automatic wait_wr_start();
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wr_start && n < 50);
    if (!wr_start) timeout_fail("wait_wr_start");
  endtask

  task automatic wait_idle(input int unsigned bound);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < bound);
    if (exp_q.size() != 0 || busy) timeout_fail("wait_idle");
  endtask

  task automatic run_single(input bq_t st);
    issue_page(st);
    page_ready = 1'b1;
    wait_wr_start();
    page_ready = 1'b0;
    wait_idle(500);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    status_q.delete();
    model_page = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Page writer model: answers wr_start with wr_page_done after a random
  // delay, and injects stray spi_done pulses during WAIT_WR and GAP.
  initial begin
    int unsigned d;
    int unsigned noise_at;
    wr_page_done   = 1'b0;
    spi_done_noise = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_start && !rst) begin
        d        = $urandom_range(2, 6);
        noise_at = $urandom_range(1, d);
        for (int i = 1; i <= d; i++) begin
          @(posedge clk);
          #1 spi_done_noise = (i == noise_at);
        end
        @(posedge clk);
        #1 spi_done_noise = 1'b0;
        wr_page_done = 1'b1;
        @(posedge clk);
        #1 wr_page_done = 1'b0;
        spi_done_noise = 1'b1;
        @(posedge clk);
        #1 spi_done_noise = 1'b0;
      end
    end
  end

  // SPI byte engine model: completes each loaded byte after 1-4 cycles;
  // dummy reads return the next scripted status byte.
  initial begin
    logic [7:0] rsp;
    spi_done_eng = 1'b0;
    spi_rx       = 8'h00;
    forever begin
      @(negedge clk);
      if (spi_load && bus_sel && !rst) begin
        if (spi_tx == 8'h05)          rsp = 8'($urandom_range(0, 255));
        else if (status_q.size() > 0) rsp = status_q.pop_front();
        else                          rsp = 8'h00;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 spi_done_eng = 1'b1;
        spi_rx = rsp;
        @(posedge clk);
        #1 spi_done_eng = 1'b0;
        spi_rx = 8'($urandom_range(0, 255));
      end
    end
  end

  // Monitor: pops the scoreboard on every DUT-visible event.
  initial begin
    ev_t         e;
    bit          ok;
    logic        prev_busy = 1'b0;
    logic        prev_ncs  = 1'b1;
    logic        prev_err  = 1'b0;
    logic [7:0]  last_tx   = 8'h00;
    bit          in_wait   = 1'b0;
    bit          sel_hi    = 1'b0;
    int unsigned wr_done_cyc = 0;
    int unsigned done0_cyc   = 0;
    int unsigned ncs_rises   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        prev_ncs  = 1'b1;
        prev_err  = 1'b0;
        in_wait   = 1'b0;
        continue;
      end
      if (in_wait && wr_page_done) begin
        chk("bus_sel_in_wait_wr", 32'(sel_hi), 0);
        wr_done_cyc = cyc;
        in_wait = 1'b0;
      end else if (in_wait && bus_sel) begin
        sel_hi = 1'b1;
      end
      if (spi_done_eng && last_tx == 8'h00 && !spi_rx[0]) done0_cyc = cyc;
      if (wr_start) begin
        pop_exp(EV_WR, e, ok);
        if (ok) chk("wr_start_page", 32'(page_addr), e.val);
        chk("wr_start_bus_sel", 32'(bus_sel), 0);
        in_wait = 1'b1;
        sel_hi  = 1'b0;
      end
      if (spi_load) begin
        pop_exp(EV_LOAD, e, ok);
        if (ok) chk("spi_tx", 32'(spi_tx), e.val);
        chk("load_ncs", 32'(ncs), 0);
        chk("load_bus_sel", 32'(bus_sel), 1);
        last_tx = spi_tx;
        if (spi_tx == 8'h05) begin
          chk("gap_latency", cyc - wr_done_cyc, CS_GAP + 2);
          ncs_rises = 0;
        end
      end
      if (ncs && !prev_ncs) ncs_rises++;
      if (err && !prev_err) begin
        pop_exp(EV_ERR, e, ok);
        if (ok) chk("err_page", 32'(page_addr), e.val);
        chk("err_ncs", 32'(ncs), 1);
        chk("err_bus_sel", 32'(bus_sel), 0);
        chk("err_busy", 32'(busy), 0);
      end else if (!busy && prev_busy) begin
        pop_exp(EV_END, e, ok);
        if (ok) begin
          chk("end_page", 32'(page_addr), e.val);
          chk("end_mem_full", 32'(mem_full), 32'(e.full));
        end
        chk("end_ncs_rises", ncs_rises, 1);
        chk("done_to_idle", cyc - done0_cyc, 3);
      end
      prev_busy = busy;
      prev_ncs  = ncs;
      prev_err  = err;
    end
  end

  initial begin
    bq_t st;
    int unsigned n;
    rst        = 1'b1;
    page_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset("por");
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single page, WIP clear on first read.
    st = {8'h00};
    run_single(st);
    // Several busy reads before WIP clears.
    st = {8'h01, 8'h01, 8'h03, 8'h00};
    run_single(st);
    // Random status pattern.
    rand_script(st);
    run_single(st);

    // Back-to-back pages with page_ready held until memory is full.
    do_reset();
    for (int p = 0; p < NUM_PAGES; p++) begin
      rand_script(st);
      issue_page(st);
    end
    page_ready = 1'b1;
    wait_idle(4000);
    repeat (30) @(negedge clk);
    page_ready = 1'b0;
    chk("full_mem_full", 32'(mem_full), 1);
    chk("full_page_addr", 32'(page_addr), NUM_PAGES - 1);
    chk("full_busy", 32'(busy), 0);

    // Reset while waiting on a status read.
    do_reset();
    st = {8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
    issue_page(st);
    page_ready = 1'b1;
    wait_wr_start();
    page_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(spi_load && spi_tx == 8'h00) && n < 100);
    if (!(spi_load && spi_tx == 8'h00)) timeout_fail("wait_rd_load");
    #2 rst = 1'b1;
    #1 check_reset("mid");
    exp_q.delete();
    status_q.delete();
    model_page = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (10) @(negedge clk);
    st = {8'h00};
    run_single(st);
    chk("restart_page_addr", 32'(page_addr), 1);

`ifdef POLL_TIMEOUT_EN
    // Device stuck busy: poll limit reached.
    do_reset();
    exp_q.push_back(mk(EV_WR, 0, 1'b0));
    exp_q.push_back(mk(EV_LOAD, 32'h05, 1'b0));
    for (int i = 0; i < MAX_POLLS; i++) exp_q.push_back(mk(EV_LOAD, 32'h00, 1'b0));
    exp_q.push_back(mk(EV_ERR, 0, 1'b0));
    for (int i = 0; i < MAX_POLLS + 3; i++) status_q.push_back(8'h01);
    page_ready = 1'b1;
    wait_wr_start();
    page_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (exp_q.size() != 0 && n < 500);
    if (exp_q.size() != 0) timeout_fail("wait_err");
    repeat (20) @(negedge clk);
    chk("to_err", 32'(err), 1);
    chk("to_ncs", 32'(ncs), 1);
    chk("to_bus_sel", 32'(bus_sel), 0);
    chk("to_page_addr", 32'(page_addr), 0);
    status_q.delete();
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eeprom_page_scheduler.md
Name: eeprom_page_scheduler

Overview:
Top-level sequencer for the SPI EEPROM logging path. It starts one page write on the page-buffer writer each time a full page of samples is ready. It then takes the SPI byte engine itself and polls the EEPROM status register (RDSR 0x05) until the internal write cycle finishes (WIP=0). Finally it advances the page address, stops at memory-full, and flags a stuck device.

Parameters:
PAGE_AW, 8, page-number width; page_addr drives EEPROM address bits [PAGE_AW+7:8]
NUM_PAGES, 256, number of writable pages; must be ≤ 2^PAGE_AW
MAX_POLLS, 1000, status reads allowed per page before error (only with POLL_TIMEOUT_EN)
CS_GAP, 4, clk cycles ncs is held high between page writer release and poll start; ≥1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
page_ready  in  1  level; buffer holds a full page
wr_start  out  1  one-cycle start pulse to page writer
wr_page_done  in  1  one-cycle pulse from page writer; its CS is released the cycle after
bus_sel  out  1  SPI mux select: 0 = page writer owns engine, 1 = this block owns it
spi_load  out  1  one-cycle load strobe to SPI byte engine (valid when bus_sel=1)
spi_tx  out  8  byte to transmit
spi_done  in  1  one-cycle pulse, byte transfer complete; spi_rx valid same cycle
spi_rx  in  8  received byte
ncs  out  1  chip select for poll transactions (active low), muxed by bus_sel
page_addr  out  PAGE_AW  current page number
busy  out  1  high in every state except IDLE, FULL, ERR
mem_full  out  1  sticky; all NUM_PAGES written
err  out  1  sticky; poll timeout

Behaviour:
- Reset values: wr_start=0, bus_sel=0, spi_load=0, spi_tx=0x00, ncs=1, page_addr=0, busy=0, mem_full=0, err=0, poll counter=0, state=IDLE.
- IDLE: if page_ready=1, go to START. Otherwise stay.
- START: wr_start=1 for exactly one cycle, bus_sel=0, go to WAIT_WR.
- WAIT_WR: wait for wr_page_done. Ignore page_ready and spi_done here.
- GAP: ncs=1, bus_sel switches to 1 on entry, count CS_GAP cycles, go to CMD.
- CMD: ncs=0, spi_tx=0x05, spi_load pulse, go to CMD_W. CMD_W: wait for spi_done, go to RD.
- RD: spi_tx=0x00 (dummy), spi_load pulse, go to RD_W. RD_W: on spi_done, latch spi_rx[0] as wip, increment poll counter, go to CHK.
- CHK, wip=1: go to RD. ncs stays low; continuous RDSR is used and the command byte is not resent.
- CHK, wip=0: ncs=1, go to NEXT.
- NEXT: clear poll counter, bus_sel=0.
  - If page_addr==NUM_PAGES-1: mem_full=1, go to FULL; page_addr holds.
  - Else: page_addr+1, go to IDLE.
- FULL: terminal; ignore page_ready. Exit only by reset.
- The FSM starts at most one transaction at a time; wr_start is never issued while bus_sel=1.
- Latency: wr_page_done to first spi_load = CS_GAP+2 cycles. WIP=0 spi_done to IDLE = 3 cycles.
- Simultaneous events: spi_done outside CMD_W/RD_W is ignored. page_ready asserted in NEXT is sampled next in IDLE.
- Reset mid-operation: all state returns to reset values immediately and ncs goes high asynchronously. The page in flight is not re-addressed; page_addr restarts at 0.

Optional Feature:
POLL_TIMEOUT_EN
- Defined: in CHK, if wip=1 and poll counter==MAX_POLLS, set ncs=1, bus_sel=0, err=1 and go to terminal ERR. Exit only by reset.
- Not defined: no poll counter is built, err is tied 0, and polling continues indefinitely.

Decomposition:
- Shared package eeprom_pkg: state encoding constants, EEPROM opcodes (RDSR 0x05, WREN 0x06, WRITE 0x02, DUMMY 0x00) and the WIP bit index. The page writer uses the same package.
- One natural sub-module: eeprom_status_poller, covering CMD through CHK, the poll counter and the timeout.
  - Inputs: start. Outputs: ready, timeout.
  - The top keeps page sequencing and the bus_sel mux control.

Test Plan:
- page_ready=1 after reset, then wr_page_done; SPI model returns status 0x00 → exactly one wr_start; SPI bytes sent 0x05, 0x00; page_addr 0→1; busy low after 3 cycles.
- Status returns 0x01, 0x01, 0x03, 0x00 → four dummy loads after a single 0x05, ncs continuously low, then page_addr increments.
- Write NUM_PAGES=4 pages back-to-back with page_ready held high → page_addr 0,1,2,3; mem_full=1 after the 4th; no 5th wr_start.
- With POLL_TIMEOUT_EN, MAX_POLLS=5, status stuck at 0x01 → exactly 5 RDSR dummy reads, then err=1, ncs=1, bus_sel=0, page_addr unchanged.
- Assert rst during RD_W → ncs=1 in the same cycle, all outputs at reset values; the next page_ready restarts at page 0.
- Inject spi_done during WAIT_WR and GAP → no state change; bus_sel=0 throughout WAIT_WR.
